// File: rtl/frame_serializer.sv
// Framed-byte serializer: takes {2'b00, payload, 2'b11} bytes, shifts them out MSB first,
// then idles for GAP_CYCLES before accepting the next byte. Malformed bytes are counted and dropped.
//
// state | meaning
// IDLE  | ready for a byte; malformed bytes are rejected here
// SHIFT | presenting bits 7..0 of the loaded byte
// GAP   | inter-frame idle, GAP_CYCLES cycles long
module frame_serializer #(
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       ser_out,
  output logic       ser_valid,
  output logic       frame_done,
  output logic [3:0] payload,
  output logic       err,
  output logic [7:0] frm_cnt,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_t     state_q, state_d;
  logic [7:0] sh_q, sh_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] gap_q, gap_d;
  logic       ready_d, ser_out_d, ser_valid_d, done_d, err_d;
  logic [3:0] payload_d;
  logic [7:0] frm_d, errc_d;
  logic       good;

  assign good = (in_data[7:6] == 2'b00) && (in_data[1:0] == 2'b11);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sh_q       <= 8'd0;
      idx_q      <= 3'd0;
      gap_q      <= 4'd0;
      in_ready   <= 1'b0;
      ser_out    <= 1'b0;
      ser_valid  <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      payload    <= 4'd0;
      frm_cnt    <= 8'd0;
      err_cnt    <= 8'd0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      in_ready   <= ready_d;
      ser_out    <= ser_out_d;
      ser_valid  <= ser_valid_d;
      frame_done <= done_d;
      err        <= err_d;
      payload    <= payload_d;
      frm_cnt    <= frm_d;
      err_cnt    <= errc_d;
    end
  end

  // idx_q is the index of the bit currently on ser_out while in SHIFT
  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    ser_out_d   = 1'b0;
    ser_valid_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    payload_d   = payload;
    frm_d       = frm_cnt;
    errc_d      = err_cnt;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          if (good) begin
            sh_d        = in_data;
            payload_d   = in_data[5:2];
            idx_d       = 3'd7;
            ser_valid_d = 1'b1;
            ser_out_d   = in_data[7];
            state_d     = SHIFT;
          end else begin
            err_d = 1'b1;
            if (err_cnt != 8'hFF) errc_d = err_cnt + 8'd1;
          end
        end
      end
      SHIFT: begin
        if (idx_q == 3'd0) begin
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            gap_d   = GAP_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          idx_d       = idx_q - 3'd1;
          ser_valid_d = 1'b1;
          ser_out_d   = sh_q[idx_d];
          if (idx_q == 3'd1) begin
            done_d = 1'b1;
            frm_d  = frm_cnt + 8'd1;
          end
        end
      end
      GAP: begin
        if (gap_q == 4'd0) state_d = IDLE;
        else gap_d = gap_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

endmodule

// File: tb/tb_frame_serializer.sv
// Bench for frame_serializer: two instances (GAP_CYCLES=1 and 0) share one stimulus stream and are
// compared every cycle against a cycle-timeline model, plus hand-computed directed expectations.
module tb_frame_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;

  logic       in_ready0, ser_out0, ser_valid0, frame_done0, err0;
  logic [3:0] payload0;
  logic [7:0] frm_cnt0, err_cnt0;
  logic       in_ready1, ser_out1, ser_valid1, frame_done1, err1;
  logic [3:0] payload1;
  logic [7:0] frm_cnt1, err_cnt1;

  int n_pass = 0;
  int n_total = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  frame_serializer #(.GAP_CYCLES(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
    .ser_out(ser_out0), .ser_valid(ser_valid0), .frame_done(frame_done0), .payload(payload0),
    .err(err0), .frm_cnt(frm_cnt0), .err_cnt(err_cnt0)
  );

  frame_serializer #(.GAP_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .ser_out(ser_out1), .ser_valid(ser_valid1), .frame_done(frame_done1), .payload(payload1),
    .err(err1), .frm_cnt(frm_cnt1), .err_cnt(err_cnt1)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    else n_pass++;
  endtask

  // Model: a good byte accepted at the end of cycle t books cycles t+1..t+8 as frame bits and the
  // following GAP cycles as idle; the block is ready in any cycle nobody booked.
  localparam int DEPTH = 1024;
  bit         m_occ[2][DEPTH];
  bit         m_val[2][DEPTH];
  bit         m_bit[2][DEPTH];
  bit         m_fin[2][DEPTH];
  bit         m_ready[2], m_so[2], m_sv[2], m_done[2], m_err[2];
  bit [3:0]   m_pay[2];
  bit [7:0]   m_frm[2], m_errc[2];
  int unsigned m_cyc = 0;

  function automatic int gap_of(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_ready[k] = 0; m_so[k] = 0; m_sv[k] = 0; m_done[k] = 0; m_err[k] = 0;
        m_pay[k] = 0; m_frm[k] = 0; m_errc[k] = 0;
        for (int i = 0; i < DEPTH; i++) begin
          m_occ[k][i] = 0; m_val[k][i] = 0; m_bit[k][i] = 0; m_fin[k][i] = 0;
        end
      end
    end else begin
      m_cyc++;
      for (int k = 0; k < 2; k++) begin
        int slot;
        slot = int'(m_cyc & 32'h3FF);
        m_err[k] = 0;
        if (in_valid && m_ready[k]) begin
          if (in_data[7:6] == 2'b00 && in_data[1:0] == 2'b11) begin
            for (int b = 0; b < 8 + gap_of(k); b++) begin
              int s;
              s = int'((m_cyc + b) & 32'h3FF);
              m_occ[k][s] = 1;
              m_fin[k][s] = (b == 7);
              if (b < 8) begin
                m_val[k][s] = 1;
                m_bit[k][s] = in_data[7 - b];
              end else begin
                m_val[k][s] = 0;
                m_bit[k][s] = 0;
              end
            end
            m_pay[k] = in_data[5:2];
          end else begin
            m_err[k] = 1;
            if (m_errc[k] != 8'd255) m_errc[k]++;
          end
        end
        m_sv[k]    = m_val[k][slot];
        m_so[k]    = m_bit[k][slot];
        m_done[k]  = m_fin[k][slot];
        if (m_done[k]) m_frm[k]++;
        m_ready[k] = !m_occ[k][slot];
        m_occ[k][slot] = 0; m_val[k][slot] = 0; m_bit[k][slot] = 0; m_fin[k][slot] = 0;
      end
    end
  end

  logic [24:0] act0, act1, exp0, exp1;
  assign act0 = {in_ready0, ser_out0, ser_valid0, frame_done0, payload0, err0, frm_cnt0, err_cnt0};
  assign act1 = {in_ready1, ser_out1, ser_valid1, frame_done1, payload1, err1, frm_cnt1, err_cnt1};
  assign exp0 = {m_ready[0], m_so[0], m_sv[0], m_done[0], m_pay[0], m_err[0], m_frm[0], m_errc[0]};
  assign exp1 = {m_ready[1], m_so[1], m_sv[1], m_done[1], m_pay[1], m_err[1], m_frm[1], m_errc[1]};

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_gap1", 32'(act0), 32'(exp0));
      chk("model_gap0", 32'(act1), 32'(exp1));
    end
  end

  task automatic wait_ready0();
    int n = 0;
    while (!in_ready0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready0) chk("wait_ready_timeout", 32'(in_ready0), 1);
  endtask

  initial begin
    logic [31:0] r;
    logic [7:0]  bits, bits2;
    logic [16:0] vpat;

    @(posedge clk);
    check_en = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready0), 0);
    chk("rst_frm_cnt", 32'(frm_cnt0), 0);
    chk("rst_ser_valid", 32'(ser_valid0), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(in_ready0), 1);

    // single good frame 0x2F
    in_data = 8'h2F; in_valid = 1'b1; bits = 8'h00;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (k <= 8) bits = {bits[6:0], ser_out0};
      if (k == 1) chk("payload_2f", 32'(payload0), 32'hB);
      if (k == 8) begin
        chk("done_at_bit0", 32'(frame_done0), 1);
        chk("frm_cnt_1", 32'(frm_cnt0), 1);
      end
      if (k == 9) begin
        chk("gap_not_ready", 32'(in_ready0), 0);
        chk("nogap_ready", 32'(in_ready1), 1);
      end
      if (k == 10) chk("ready_after_gap", 32'(in_ready0), 1);
    end
    chk("bits_2f", 32'(bits), 32'h2F);

    // bad trailer 0x2C
    in_data = 8'h2C; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("bad_err", 32'(err0), 1);
    chk("bad_err_cnt", 32'(err_cnt0), 1);
    chk("bad_no_valid", 32'(ser_valid0), 0);
    chk("bad_still_ready", 32'(in_ready0), 1);
    chk("bad_payload_kept", 32'(payload0), 32'hB);
    chk("bad_err_gap0", 32'(err1), 1);

    // back-to-back frames on the zero-gap instance
    in_data = 8'h2F; in_valid = 1'b1; vpat = '0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 17) in_valid = 1'b0;
      vpat = {vpat[15:0], ser_valid1};
    end
    chk("b2b_valid_pattern", 32'(vpat), 32'h1FEFF);
    chk("b2b_frm_cnt", 32'(frm_cnt1), 3);

    // valid held with new data while busy
    wait_ready0();
    in_data = 8'h2F; in_valid = 1'b1; bits = 8'h00; bits2 = 8'h00;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) in_data = 8'h17;
      if (k == 11) in_valid = 1'b0;
      if (k <= 8) bits = {bits[6:0], ser_out0};
      if (k >= 11) bits2 = {bits2[6:0], ser_out0};
      if (k == 5 || k == 9) chk("hold_not_ready", 32'(in_ready0), 0);
      if (k == 10) chk("hold_ready", 32'(in_ready0), 1);
      if (k == 11) chk("hold_payload", 32'(payload0), 32'h5);
    end
    chk("hold_first_bits", 32'(bits), 32'h2F);
    chk("hold_second_bits", 32'(bits2), 32'h17);

    // random traffic
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      r = $urandom;
      in_valid = r[31];
      if ($urandom_range(0, 9) < 7) in_data = {2'b00, r[3:0], 2'b11};
      else in_data = r[15:8];
    end
    in_valid = 1'b0;

    // reset during bit 4 of 0x3F
    wait_ready0();
    in_data = 8'h3F; in_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    chk("abort_bit4_valid", 32'(ser_valid0), 1);
    chk("abort_bit4_value", 32'(ser_out0), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_outs_gap1", 32'(act0), 0);
    chk("abort_outs_gap0", 32'(act1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", 32'(in_ready0), 1);
    chk("abort_frm_cnt", 32'(frm_cnt0), 0);
    chk("abort_no_valid", 32'(ser_valid0), 0);

    // frame counter wrap, then error counter saturation
    for (int f = 0; f < 256; f++) begin
      wait_ready0();
      r = $urandom;
      in_data = {2'b00, r[3:0], 2'b11}; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
    end
    wait_ready0();
    chk("frm_wrap_gap1", 32'(frm_cnt0), 0);
    chk("frm_wrap_gap0", 32'(frm_cnt1), 0);
    in_valid = 1'b1;
    for (int e = 0; e < 300; e++) begin
      r = $urandom;
      in_data = r[7:0] | 8'h80;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("err_sat_gap1", 32'(err_cnt0), 255);
    chk("err_sat_gap0", 32'(err_cnt1), 255);
    repeat (3) @(negedge clk);

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
